key_event_arbiter: RTL and testbench

KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

---
 rtl/key_pkg.sv | 16 +
 rtl/key_tick_gen.sv | 25 ++
 rtl/key_event_arbiter.sv | 173 +++++++++++++++++
 tb/tb_key_event_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
`default_nettype none
// ============================================================================
// key_pkg : shared widths, defaults and FSM encoding for key_event_arbiter
// Rev 1.0
// ============================================================================
package key_pkg;
  localparam int N_KEYS_DEF = 18;
  localparam int KEY_IDX_W  = 5;
  localparam int AGREE_W    = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_t;
endpackage
`default_nettype wire

// File: rtl/key_tick_gen.sv
`default_nettype none
// ============================================================================
// key_tick_gen : one-cycle sample tick every TICK_DIV clocks (power of two)
// Rev 1.0
// ============================================================================
module key_tick_gen #(
  parameter int TICK_DIV = 65536
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0] r_cnt;

  // Free-running wrap counter; all-ones marks the TICK_DIV-th cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_cnt <= '0;
    else      r_cnt <= r_cnt + CNT_W'(1);
  end

  assign tick = (r_cnt == {CNT_W{1'b1}});
endmodule
`default_nettype wire

// File: rtl/key_event_arbiter.sv
`default_nettype none
// ============================================================================
// key_event_arbiter : per-key debounce plus round-robin press/release events
// Rev 1.0
// ============================================================================
module key_event_arbiter
  import key_pkg::*;
#(
  parameter int N_KEYS     = N_KEYS_DEF,
  parameter int TICK_DIV   = 65536,
  parameter int STABLE_CNT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_KEYS-1:0]    key_in,
  output logic [N_KEYS-1:0]    key_state,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [KEY_IDX_W-1:0] evt_key,
  output logic                 evt_press,
  output logic [N_KEYS-1:0]    pending,
  output logic                 overflow,
  input  logic                 clr_overflow
);
  localparam int CAND_W = KEY_IDX_W + 1;

  logic [N_KEYS-1:0]    r_sync1, r_sync2;
  logic [N_KEYS-1:0]    w_key_state, w_pending, w_dir, w_accept, w_ovf;
  logic                 w_tick, w_hs;
  arb_state_t           r_fsm, w_fsm_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [KEY_IDX_W-1:0] r_evt_key, w_key_nxt, r_last, w_last_nxt, w_win;
  logic                 r_evt_press, w_press_nxt, r_dirty, w_dirty_nxt, w_found;
  logic [CAND_W-1:0]    w_cand;
  logic                 r_ovf;

  key_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_hs = r_valid & evt_ready;

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    localparam logic [KEY_IDX_W-1:0] c_idx = KEY_IDX_W'(k);
    logic [AGREE_W-1:0] r_agree;
    logic               r_lvl, r_pend, r_dir;
    logic               w_diff, w_granted;

    assign w_diff      = r_sync2[k] ^ r_lvl;
    assign w_accept[k] = w_tick & w_diff & (r_agree == AGREE_W'(STABLE_CNT - 1));
    assign w_granted   = w_hs & (r_evt_key == c_idx);
    // A change landing in the handshake cycle replaces, rather than overwrites, the delivered event.
    assign w_ovf[k]    = w_accept[k] & r_pend & ~w_granted;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_agree <= '0;
        r_lvl   <= 1'b0;
        r_pend  <= 1'b0;
        r_dir   <= 1'b0;
      end else begin
        if (w_tick) begin
          if (w_accept[k]) begin
            r_agree <= '0;
            r_lvl   <= ~r_lvl;
          end else if (w_diff) begin
            r_agree <= r_agree + AGREE_W'(1);
          end else begin
            r_agree <= '0;
          end
        end
        if (w_accept[k]) begin
          r_pend <= 1'b1;
          r_dir  <= ~r_lvl;
        end else if (w_granted && !r_dirty) begin
          r_pend <= 1'b0;
        end
      end
    end

    assign w_key_state[k] = r_lvl;
    assign w_pending[k]   = r_pend;
    assign w_dir[k]       = r_dir;
  end

  // Round-robin search starting just after the last granted key.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_cand = {1'b0, r_last} + CAND_W'(i + 1);
      if (w_cand >= CAND_W'(N_KEYS)) w_cand = w_cand - CAND_W'(N_KEYS);
      if (!w_found && w_pending[w_cand[KEY_IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_cand[KEY_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_valid_nxt = r_valid;
    w_key_nxt   = r_evt_key;
    w_press_nxt = r_evt_press;
    w_last_nxt  = r_last;
    w_dirty_nxt = r_dirty;
    case (r_fsm)
      ST_IDLE: begin
        if (w_found) begin
          w_fsm_nxt   = ST_OFFER;
          w_valid_nxt = 1'b1;
          w_key_nxt   = w_win;
          w_press_nxt = w_dir[w_win];
          w_dirty_nxt = 1'b0;
        end
      end
      ST_OFFER: begin
        if (w_hs) begin
          w_fsm_nxt   = ST_IDLE;
          w_valid_nxt = 1'b0;
          w_last_nxt  = r_evt_key;
          w_dirty_nxt = 1'b0;
        end else if (w_accept[r_evt_key]) begin
          // Offered key changed again: its stored copy must survive the handshake.
          w_dirty_nxt = 1'b1;
        end
      end
      default: w_fsm_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm       <= ST_IDLE;
      r_valid     <= 1'b0;
      r_evt_key   <= '0;
      r_evt_press <= 1'b0;
      r_last      <= KEY_IDX_W'(N_KEYS - 1);
      r_dirty     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_valid     <= w_valid_nxt;
      r_evt_key   <= w_key_nxt;
      r_evt_press <= w_press_nxt;
      r_last      <= w_last_nxt;
      r_dirty     <= w_dirty_nxt;
      if (|w_ovf)            r_ovf <= 1'b1;
      else if (clr_overflow) r_ovf <= 1'b0;
    end
  end

  assign key_state = w_key_state;
  assign pending   = w_pending;
  assign evt_valid = r_valid;
  assign evt_key   = r_evt_key;
  assign evt_press = r_evt_press;
  assign overflow  = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_key_event_arbiter.sv
`default_nettype none
// ============================================================================
// tb_key_event_arbiter : directed stimulus with queued expected events
// Rev 1.0
// ============================================================================
module tb_key_event_arbiter;
  localparam int N = 18;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key_in;
  logic [N-1:0] key_state, pending;
  logic         evt_valid, evt_ready, evt_press, overflow, clr_overflow;
  logic [4:0]   evt_key;

  typedef struct packed {
    logic [4:0] key;
    logic       press;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  key_event_arbiter #(.N_KEYS(N), .TICK_DIV(4), .STABLE_CNT(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .key_state    (key_state),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_key      (evt_key),
    .evt_press    (evt_press),
    .pending      (pending),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_ev(input int key, input logic press);
    ev_t e;
    e.key   = 5'(key);
    e.press = press;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: actual key=%0d press=%0b required none", evt_key, evt_press);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("event_key", 32'(evt_key), 32'(e.key));
        chk("event_press", 32'(evt_press), 32'(e.press));
      end
    end
  end

  initial begin
    rst          = 1'b0;
    key_in       = '0;
    evt_ready    = 1'b1;
    clr_overflow = 1'b0;
    step(3);
    rst = 1'b1;
    step(1);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_evt_valid", 32'(evt_valid), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);

    // Single press on key 5
    key_in[5] = 1'b1;
    expect_ev(5, 1'b1);
    step(6);
    chk("s1_early_state", 32'(key_state[5]), 32'h0);
    step(30);
    chk("s1_key_state", 32'(key_state[5]), 32'h1);
    chk("s1_pending_clr", 32'(pending[5]), 32'h0);
    chk("s1_q_empty", 32'(exp_q.size()), 32'h0);

    // Key 2 chattering once per tick never settles
    for (int i = 0; i < 10; i++) begin
      key_in[2] = ~key_in[2];
      step(4);
    end
    step(20);
    chk("s2_key_state", 32'(key_state[2]), 32'h0);
    chk("s2_pending", 32'(pending[2]), 32'h0);
    chk("s2_q_empty", 32'(exp_q.size()), 32'h0);

    // Simultaneous presses after last grant 5
    key_in[3]  = 1'b1;
    key_in[7]  = 1'b1;
    key_in[17] = 1'b1;
    expect_ev(7, 1'b1);
    expect_ev(17, 1'b1);
    expect_ev(3, 1'b1);
    step(40);
    chk("s3_press_q_empty", 32'(exp_q.size()), 32'h0);
    chk("s3_key_state", 32'(key_state), 32'h200A8);
    key_in[3]  = 1'b0;
    key_in[5]  = 1'b0;
    key_in[7]  = 1'b0;
    key_in[17] = 1'b0;
    expect_ev(5, 1'b0);
    expect_ev(7, 1'b0);
    expect_ev(17, 1'b0);
    expect_ev(3, 1'b0);
    step(40);
    chk("s3_release_q_empty", 32'(exp_q.size()), 32'h0);

    // Key 4 pressed and released while consumer stalls on key 0
    evt_ready = 1'b0;
    key_in[0] = 1'b1;
    step(30);
    chk("s4_offer_valid", 32'(evt_valid), 32'h1);
    chk("s4_offer_key", 32'(evt_key), 32'h0);
    key_in[4] = 1'b1;
    step(30);
    chk("s4_pend4_set", 32'(pending[4]), 32'h1);
    chk("s4_no_ovf_yet", 32'(overflow), 32'h0);
    key_in[4] = 1'b0;
    step(30);
    chk("s4_overflow", 32'(overflow), 32'h1);
    chk("s4_pend4_held", 32'(pending[4]), 32'h1);
    chk("s4_key4_state", 32'(key_state[4]), 32'h0);
    expect_ev(0, 1'b1);
    expect_ev(4, 1'b0);
    evt_ready = 1'b1;
    step(20);
    chk("s4_q_empty", 32'(exp_q.size()), 32'h0);
    chk("s4_pending_clr", 32'(pending), 32'h0);
    chk("s4_ovf_sticky", 32'(overflow), 32'h1);
    clr_overflow = 1'b1;
    step(1);
    clr_overflow = 1'b0;
    chk("s4_ovf_cleared", 32'(overflow), 32'h0);
    key_in[0] = 1'b0;
    expect_ev(0, 1'b0);
    step(30);
    chk("s4_rel_q_empty", 32'(exp_q.size()), 32'h0);

    // Reset while key 9 is being offered
    evt_ready = 1'b0;
    key_in[9] = 1'b1;
    expect_ev(9, 1'b1);
    for (int i = 0; i < 40 && !evt_valid; i++) step(1);
    chk("s5_offer_valid", 32'(evt_valid), 32'h1);
    chk("s5_offer_key", 32'(evt_key), 32'h9);
    key_in[9] = 1'b0;
    rst = 1'b0;
    #1;
    chk("s5_rst_valid", 32'(evt_valid), 32'h0);
    chk("s5_rst_key", 32'(evt_key), 32'h0);
    chk("s5_rst_press", 32'(evt_press), 32'h0);
    chk("s5_rst_state", 32'(key_state), 32'h0);
    chk("s5_rst_pending", 32'(pending), 32'h0);
    chk("s5_rst_ovf", 32'(overflow), 32'h0);
    exp_q.delete();
    step(3);
    rst       = 1'b1;
    evt_ready = 1'b1;
    step(40);
    chk("s5_post_state", 32'(key_state), 32'h0);
    chk("s5_post_pending", 32'(pending), 32'h0);
    chk("s5_post_valid", 32'(evt_valid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
